ecc_modaddsub_ctrl: RTL

Sequencer that computes modular addition and subtraction, (a ± b) mod P, over a 256-bit prime field by time-sharing one combinational `brent_kung_adder258` across several passes. It sits between the ECC point-arithmetic scheduler and the adder. It accepts one operation at a time over a valid/ready handshake and returns a registered, reduced result.

---
 rtl/ecc_arith_pkg.sv | 32 +++
 rtl/brent_kung_adder258.sv | 50 +++++
 rtl/ecc_modaddsub_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ecc_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_arith_pkg
//  Description : Shared widths, op encodings and FSM state encoding for the
//                ECC modular add/sub sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ecc_arith_pkg;

  localparam int FW = 256;  // field element width
  localparam int AW = 258;  // adder operand width (two guard bits)

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    SUB1 = 3'd3,
    SUB2 = 3'd4,
    SUB3 = 3'd5,
    DONE = 3'd6
  } state_e;

  // Zero-extend a field element to adder operand width.
  function automatic logic [AW-1:0] zext(input logic [FW-1:0] v);
    return {{(AW-FW){1'b0}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/brent_kung_adder258.sv
`default_nettype none
// ============================================================================
//  Module      : brent_kung_adder258
//  Description : 258-bit combinational Brent-Kung parallel-prefix adder with
//                carry out (S[258]). No carry in.
//  Revision    : 1.0 - initial release
// ============================================================================
module brent_kung_adder258 (
  input  logic [257:0] A,
  input  logic [257:0] B,
  output logic [258:0] S
);

  localparam int W   = 258;
  localparam int LOG = 9;   // ceil(log2(W))
  localparam int IW  = 9;   // index width for bit selects

  logic [W-1:0] w_p0;  // bitwise propagate, kept for the sum XOR
  logic [W-1:0] w_gg;  // group generate, becomes full prefix carry
  logic [W-1:0] w_pp;  // group propagate after the up-sweep

  // Prefix network: up-sweep builds power-of-two groups, down-sweep fills
  // the remaining positions from the nearest completed prefix below them.
  always_comb begin
    w_p0 = A ^ B;
    w_gg = A & B;
    w_pp = A ^ B;
    for (int l = 0; l < LOG; l++) begin
      for (int i = 0; i < W; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          w_gg[IW'(i)] = w_gg[IW'(i)] | (w_pp[IW'(i)] & w_gg[IW'(i - (1 << l))]);
          w_pp[IW'(i)] = w_pp[IW'(i)] & w_pp[IW'(i - (1 << l))];
        end
      end
    end
    // Each down-sweep node is touched once; its up-sweep propagate covers
    // exactly the gap to the source node, which already holds a full prefix.
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = 0; i < W; i++) begin
        if ((i >= (1 << l)) && (((i + 1) % (1 << (l + 1))) == (1 << l))) begin
          w_gg[IW'(i)] = w_gg[IW'(i)] | (w_pp[IW'(i)] & w_gg[IW'(i - (1 << l))]);
        end
      end
    end
  end

  assign S = {w_gg[W-1], w_p0 ^ {w_gg[W-2:0], 1'b0}};

endmodule
`default_nettype wire

// File: rtl/ecc_modaddsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_modaddsub_ctrl
//  Description : Multi-pass sequencer computing (a +/- b) mod P by sharing a
//                single 258-bit Brent-Kung adder across 2-3 passes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecc_modaddsub_ctrl
  import ecc_arith_pkg::*;
#(
  parameter logic [FW-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          op,
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] res,
  output logic          busy
);

  // Two's complement of P at adder width: adding it subtracts P.
  localparam logic [AW-1:0] NEG_P = ~zext(P) + {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [FW-1:0] a_q, a_d;
  logic [FW-1:0] b_q, b_d;
  logic [AW-1:0] t_q, t_d;
  logic          bz_q, bz_d;
  logic [FW-1:0] res_q, res_d;

  logic [AW-1:0] w_x;
  logic [AW-1:0] w_y;
  logic [AW:0]   w_s;
  logic          w_borrow;

  brent_kung_adder258 u_adder (
    .A (w_x),
    .B (w_y),
    .S (w_s)
  );

  // Next-state, adder operand selection and pass result capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    t_d      = t_q;
    bz_d     = bz_q;
    res_d    = res_q;
    w_x      = '0;
    w_y      = '0;
    w_borrow = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = (op == OP_SUB) ? SUB1 : ADD1;
        end
      end
      ADD1: begin
        w_x     = zext(a_q);
        w_y     = zext(b_q);
        t_d     = w_s[AW-1:0];
        state_d = ADD2;
      end
      ADD2: begin
        // Carry out of t + (2^258 - P) means t >= P, so take the reduced sum.
        w_x     = t_q;
        w_y     = NEG_P;
        res_d   = w_s[AW] ? w_s[FW-1:0] : t_q[FW-1:0];
        state_d = DONE;
      end
      SUB1: begin
        // 2^258 - b; the carry out flags b == 0, where the negation wraps to 0.
        w_x     = ~zext(b_q);
        w_y     = {{(AW-1){1'b0}}, 1'b1};
        t_d     = w_s[AW-1:0];
        bz_d    = w_s[AW];
        state_d = SUB2;
      end
      SUB2: begin
        w_x      = zext(a_q);
        w_y      = t_q;
        w_borrow = ~(w_s[AW] | bz_q);
        if (!w_borrow) begin
          res_d   = w_s[FW-1:0];
          state_d = DONE;
        end else begin
          t_d     = w_s[AW-1:0];
          state_d = SUB3;
        end
      end
      SUB3: begin
        // a - b went negative; adding P brings it back into range.
        w_x     = t_q;
        w_y     = zext(P);
        res_d   = w_s[FW-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      bz_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      bz_q    <= bz_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = res_q;

endmodule
`default_nettype wire
